store_unit: RTL and testbench

Memory-store stage for the MAXICORE32 pipeline; it is the write-side counterpart to the stage-2 load/writeback logic. It takes a STORE instruction plus its byte address and register data, then aligns and truncates the data to byte, word or long. It drives one handshaken write cycle on the data bus, holding the pipeline stalled until the bus acknowledges. Misaligned stores are rejected without a bus cycle.

---
 rtl/store_unit.sv | 141 ++++++++++++++
 tb/tb_store_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_unit.sv
// store_unit: MAXICORE32 memory-store stage. It aligns store data onto a big-endian 32-bit bus and runs one handshaken write cycle.
// Optional access timeout: define STORE_TIMEOUT_EN to abort a write that is never acknowledged.
//
// state  | meaning
// IDLE   | accepting instructions, forwarding non-stores, rejecting misaligned stores
// ACCESS | write cycle outstanding, pipeline stalled until bus_ack (or timeout)
module store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [4:0]  OPCODE_STORE   = 5'h0A,
    parameter logic [4:0]  OPCODE_NOP     = 5'h00,
    parameter logic [1:0]  CW_BYTE        = 2'b00,
    parameter logic [1:0]  CW_WORD        = 2'b01
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] inbound_instruction,
    input  logic [31:0] store_address,
    input  logic [31:0] store_data,
    output logic        bus_request,
    output logic        bus_write,
    output logic [29:0] bus_address,
    output logic [31:0] bus_data_out,
    output logic [3:0]  bus_data_strobes,
    input  logic        bus_ack,
    output logic        stall,
    output logic        bus_error,
    output logic [31:0] outbound_instruction
);

    localparam logic [0:0]  ST_IDLE   = 1'b0;
    localparam logic [0:0]  ST_ACCESS = 1'b1;
    localparam logic [31:0] NOP_INSTR = {OPCODE_NOP, 27'h0};

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
        $error("store_unit: TIMEOUT_CYCLES must be within 2..255");
    end

    logic [0:0]  state;
    logic [31:0] held_instruction;

    logic [4:0]  opcode;
    logic [1:0]  cycle_width;
    logic        is_store;
    logic        misaligned;
    logic [31:0] lane_data;
    logic [3:0]  lane_strobes;

    assign opcode      = inbound_instruction[31:27];
    assign cycle_width = inbound_instruction[26:25];
    assign is_store    = (opcode == OPCODE_STORE);

    // Big-endian lanes: byte lane 0 of the word is bits 31:24, so strobes shift right with the address.
    always_comb begin
        lane_data    = store_data;
        lane_strobes = 4'b1111;
        misaligned   = 1'b0;
        if (cycle_width == CW_BYTE) begin
            lane_data    = {4{store_data[7:0]}};
            lane_strobes = 4'b1000 >> store_address[1:0];
        end else if (cycle_width == CW_WORD) begin
            lane_data    = {2{store_data[15:0]}};
            lane_strobes = store_address[1] ? 4'b0011 : 4'b1100;
            misaligned   = store_address[0];
        end else begin
            misaligned   = |store_address[1:0];
        end
    end

    assign bus_write = bus_request;

`ifdef STORE_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_count;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                <= ST_IDLE;
            held_instruction     <= NOP_INSTR;
            bus_request          <= 1'b0;
            bus_address          <= 30'h0;
            bus_data_out         <= 32'h0;
            bus_data_strobes     <= 4'b0000;
            stall                <= 1'b0;
            bus_error            <= 1'b0;
            outbound_instruction <= NOP_INSTR;
`ifdef STORE_TIMEOUT_EN
            wait_count           <= 8'h0;
`endif
        end else begin
            bus_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (is_store && misaligned) begin
                        bus_error            <= 1'b1;
                        outbound_instruction <= NOP_INSTR;
                    end else if (is_store) begin
                        held_instruction     <= inbound_instruction;
                        bus_address          <= store_address[31:2];
                        bus_data_out         <= lane_data;
                        bus_data_strobes     <= lane_strobes;
                        bus_request          <= 1'b1;
                        stall                <= 1'b1;
                        outbound_instruction <= NOP_INSTR;
                        state                <= ST_ACCESS;
`ifdef STORE_TIMEOUT_EN
                        wait_count           <= 8'h0;
`endif
                    end else begin
                        outbound_instruction <= inbound_instruction;
                    end
                end
                ST_ACCESS: begin
                    // An ack on the final allowed cycle takes priority over the timeout.
                    if (bus_ack) begin
                        bus_request          <= 1'b0;
                        bus_data_strobes     <= 4'b0000;
                        stall                <= 1'b0;
                        outbound_instruction <= held_instruction;
                        state                <= ST_IDLE;
`ifdef STORE_TIMEOUT_EN
                    end else if (wait_count == TIMEOUT_LAST) begin
                        bus_request          <= 1'b0;
                        bus_data_strobes     <= 4'b0000;
                        stall                <= 1'b0;
                        bus_error            <= 1'b1;
                        outbound_instruction <= NOP_INSTR;
                        state                <= ST_IDLE;
                    end else begin
                        wait_count           <= wait_count + 8'd1;
`endif
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: table vectors, hand sequences and randomized stores checked against a lane-arithmetic model of store_unit.
// Define STORE_TIMEOUT_EN for both files to exercise the timeout build (TIMEOUT_CYCLES=4).
module tb_store_unit;

    localparam logic [4:0] OP_STORE = 5'h0A;
    localparam logic [4:0] OP_NOP   = 5'h00;
    localparam logic [1:0] W_BYTE   = 2'b00;
    localparam logic [1:0] W_WORD   = 2'b01;
    localparam logic [1:0] W_LONG   = 2'b10;
    localparam logic [31:0] NOP_WORD = {OP_NOP, 27'h0};
`ifdef STORE_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 16;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] inbound = 32'h0;
    logic [31:0] store_address = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        bus_request;
    logic        bus_write;
    logic [29:0] bus_address;
    logic [31:0] bus_data_out;
    logic [3:0]  bus_data_strobes;
    logic        bus_ack = 1'b0;
    logic        stall;
    logic        bus_error;
    logic [31:0] outbound;

    int checks = 0;
    int passed = 0;

    store_unit #(
        .TIMEOUT_CYCLES(TO),
        .OPCODE_STORE(OP_STORE),
        .OPCODE_NOP(OP_NOP),
        .CW_BYTE(W_BYTE),
        .CW_WORD(W_WORD)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .inbound_instruction(inbound),
        .store_address(store_address),
        .store_data(store_data),
        .bus_request(bus_request),
        .bus_write(bus_write),
        .bus_address(bus_address),
        .bus_data_out(bus_data_out),
        .bus_data_strobes(bus_data_strobes),
        .bus_ack(bus_ack),
        .stall(stall),
        .bus_error(bus_error),
        .outbound_instruction(outbound)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    function automatic logic [31:0] nonstore();
        logic [4:0] op;
        op = 5'($urandom_range(0, 31));
        if (op == OP_STORE) op = OP_NOP;
        return {op, 27'($urandom)};
    endfunction

    // Reference: replicate the source bytes by multiplication, pick the lane from the byte offset.
    function automatic void model(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d,
                                  output bit err, output logic [31:0] md, output logic [3:0] ms);
        int lane;
        lane = int'(a[1:0]);
        if (w == W_BYTE) begin
            err = 1'b0;
            md  = {24'h0, d[7:0]} * 32'h01010101;
            ms  = 4'(1 << (3 - lane));
        end else if (w == W_WORD) begin
            err = (lane % 2) != 0;
            md  = {16'h0, d[15:0]} * 32'h00010001;
            ms  = (lane >= 2) ? 4'b0011 : 4'b1100;
        end else begin
            err = lane != 0;
            md  = d;
            ms  = 4'b1111;
        end
    endfunction

    task automatic run_store(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d, input int delay,
                             input bit e_err, input logic [29:0] e_addr, input logic [31:0] e_data,
                             input logic [3:0] e_strb);
        logic [31:0] ins;
        logic [31:0] filler;
        ins = {OP_STORE, w, 25'($urandom)};
        inbound = ins;
        store_address = a;
        store_data = d;
        bus_ack = 1'b0;
        tick();
        if (e_err) begin
            chk("mis_error", bus_error, 1);
            chk("mis_request", bus_request, 0);
            chk("mis_strobes", bus_data_strobes, 0);
            chk("mis_outbound", outbound, NOP_WORD);
            filler = nonstore();
            inbound = filler;
            tick();
            chk("mis_error_pulse", bus_error, 0);
            chk("mis_forward_next", outbound, filler);
            return;
        end
        chk("req_high", bus_request, 1);
        chk("write_high", bus_write, 1);
        chk("stall_high", stall, 1);
        chk("address", bus_address, e_addr);
        chk("data", bus_data_out, e_data);
        chk("strobes", bus_data_strobes, e_strb);
        chk("outbound_nop", outbound, NOP_WORD);
        // Inputs are ignored during ACCESS, even another store.
        inbound = {OP_STORE, 27'($urandom)};
        store_address = $urandom;
        store_data = $urandom;
        for (int k = 1; k < delay; k++) begin
            tick();
            chk("wait_req", bus_request, 1);
            chk("wait_stall", stall, 1);
            chk("wait_address", bus_address, e_addr);
            chk("wait_data", bus_data_out, e_data);
            chk("wait_strobes", bus_data_strobes, e_strb);
            chk("wait_error", bus_error, 0);
        end
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        chk("done_req", bus_request, 0);
        chk("done_write", bus_write, 0);
        chk("done_stall", stall, 0);
        chk("done_strobes", bus_data_strobes, 0);
        chk("done_forward", outbound, ins);
        chk("done_error", bus_error, 0);
        inbound = NOP_WORD;
    endtask

    typedef struct {
        logic [1:0]  w;
        logic [31:0] a;
        logic [31:0] d;
        int          delay;
        bit          err;
        logic [29:0] ea;
        logic [31:0] ed;
        logic [3:0]  es;
    } vec_t;

    vec_t vecs[9];

    initial begin
        bit          m_err;
        logic [31:0] m_data;
        logic [3:0]  m_strb;
        logic [31:0] ins;
        int          dly;

        vecs[0] = '{W_LONG, 32'h0000_1000, 32'hDEAD_BEEF, 1, 1'b0, 30'h400, 32'hDEAD_BEEF, 4'b1111};
        vecs[1] = '{W_BYTE, 32'h0000_2003, 32'h1234_56AB, 1, 1'b0, 30'h800, 32'hABAB_ABAB, 4'b0001};
        vecs[2] = '{W_BYTE, 32'h0000_2000, 32'h1234_56AB, 2, 1'b0, 30'h800, 32'hABAB_ABAB, 4'b1000};
        vecs[3] = '{W_WORD, 32'h0000_3002, 32'hFFFF_1234, 5, 1'b0, 30'hC00, 32'h1234_1234, 4'b0011};
        vecs[4] = '{W_LONG, 32'h0000_4001, 32'h0BAD_F00D, 1, 1'b1, 30'h0, 32'h0, 4'b0000};
        vecs[5] = '{W_WORD, 32'h0000_4003, 32'h0BAD_F00D, 1, 1'b1, 30'h0, 32'h0, 4'b0000};
        vecs[6] = '{W_WORD, 32'h0000_3000, 32'hABCD_5678, 3, 1'b0, 30'hC00, 32'h5678_5678, 4'b1100};
        vecs[7] = '{W_BYTE, 32'h0000_2001, 32'h0000_00C3, 1, 1'b0, 30'h800, 32'hC3C3_C3C3, 4'b0100};
        vecs[8] = '{W_BYTE, 32'h0000_2002, 32'hFFFF_FF5A, 2, 1'b0, 30'h800, 32'h5A5A_5A5A, 4'b0010};

        // Reset values
        reset_n = 1'b0;
        tick();
        tick();
        chk("rst_request", bus_request, 0);
        chk("rst_write", bus_write, 0);
        chk("rst_stall", stall, 0);
        chk("rst_error", bus_error, 0);
        chk("rst_address", bus_address, 0);
        chk("rst_data", bus_data_out, 0);
        chk("rst_strobes", bus_data_strobes, 0);
        chk("rst_outbound", outbound, NOP_WORD);
        reset_n = 1'b1;
        tick();

        // Non-store forwarding with bus_ack held high in IDLE
        bus_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ins = nonstore();
            inbound = ins;
            tick();
            chk("fwd_outbound", outbound, ins);
            chk("fwd_request", bus_request, 0);
            chk("fwd_strobes", bus_data_strobes, 0);
        end
        bus_ack = 1'b0;

        foreach (vecs[i]) begin
            dly = (vecs[i].delay > TO) ? TO : vecs[i].delay;
            run_store(vecs[i].w, vecs[i].a, vecs[i].d, dly, vecs[i].err, vecs[i].ea, vecs[i].ed, vecs[i].es);
        end

        // Reset during ACCESS
        inbound = {OP_STORE, W_LONG, 25'h0};
        store_address = 32'h0000_6000;
        store_data = 32'hCAFE_F00D;
        tick();
        chk("mid_req_before", bus_request, 1);
        tick();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_request", bus_request, 0);
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_strobes", bus_data_strobes, 0);
        chk("mid_rst_address", bus_address, 0);
        chk("mid_rst_data", bus_data_out, 0);
        chk("mid_rst_outbound", outbound, NOP_WORD);
        tick();
        reset_n = 1'b1;
        inbound = {OP_NOP, 27'h0000ABC};
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        chk("post_rst_forward", outbound, {OP_NOP, 27'h0000ABC});
        chk("post_rst_request", bus_request, 0);
        chk("post_rst_error", bus_error, 0);

`ifdef STORE_TIMEOUT_EN
        inbound = {OP_STORE, W_LONG, 25'h1};
        store_address = 32'h0000_5000;
        store_data = 32'h1111_2222;
        tick();
        chk("to_req_start", bus_request, 1);
        for (int k = 1; k < TO; k++) begin
            tick();
            chk("to_req_hold", bus_request, 1);
            chk("to_no_error", bus_error, 0);
        end
        tick();
        chk("to_req_drop", bus_request, 0);
        chk("to_stall_drop", stall, 0);
        chk("to_error", bus_error, 1);
        chk("to_outbound", outbound, NOP_WORD);
        chk("to_strobes", bus_data_strobes, 0);
        inbound = NOP_WORD;
        tick();
        chk("to_error_pulse", bus_error, 0);
        run_store(W_LONG, 32'h0000_5004, 32'h3333_4444, TO, 1'b0, 30'h1401, 32'h3333_4444, 4'b1111);
`else
        run_store(W_WORD, 32'h0000_7002, 32'h0000_BEEF, 20, 1'b0, 30'h1C00, 32'hBEEF_BEEF, 4'b0011);
`endif

        // Randomized stores and non-stores, back to back
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                ins = nonstore();
                inbound = ins;
                tick();
                chk("rnd_forward", outbound, ins);
                chk("rnd_idle_request", bus_request, 0);
            end else begin
                logic [1:0]  w;
                logic [31:0] a;
                logic [31:0] d;
                w = 2'($urandom_range(0, 3));
                a = $urandom;
                d = $urandom;
                model(w, a, d, m_err, m_data, m_strb);
                dly = $urandom_range(1, (TO < 6) ? TO : 6);
                run_store(w, a, d, dly, m_err, a[31:2], m_data, m_strb);
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
